mc8051_instr_sequencer: RTL and testbench

Instruction fetch and stage sequencer for the mc8051 core.
- Sits directly upstream of op_decoder.
- Fetches opcode and operand bytes from program memory over a req/ack handshake, and holds the opcode in the instruction buffer.
- Steps the 2-bit ci_stage index that addresses the microcode table.
- Advances the stage using the end-of-instruction, stall and PC-load controls returned by the decoded microcode word.

---
 rtl/mc8051_instr_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mc8051_instr_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc8051_instr_sequencer.sv
// mc8051 instruction fetch and stage sequencer.
// Fetches opcode/operand bytes and steps ci_stage for op_decoder.
module mc8051_instr_sequencer #(
    parameter int                   PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_mem_req,
    output logic [PC_WIDTH-1:0] o_mem_addr,
    input  logic                i_mem_ack,
    input  logic [7:0]          i_mem_rdata,
    output logic [7:0]          o_instr_buffer,
    output logic [1:0]          o_ci_stage,
    output logic                o_mc_valid,
    output logic [7:0]          o_opr0,
    output logic [7:0]          o_opr1,
    output logic [PC_WIDTH-1:0] o_pc,
    input  logic                i_mc_last,
    input  logic                i_mc_stall,
    input  logic                i_opr_req,
    input  logic                i_pc_load,
    input  logic [PC_WIDTH-1:0] i_pc_load_addr,
    output logic                o_seq_err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_OPR   = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [7:0]          instr_q;
    logic [1:0]          stage_q;
    logic                mc_valid_q;
    logic [7:0]          opr0_q;
    logic [7:0]          opr1_q;
    logic [1:0]          cnt_q;
    logic                seq_err_q;
    logic                req_q;
    logic                last_q;
    logic                pcld_q;
    logic [PC_WIDTH-1:0] pcld_addr_q;

    logic                use_reg;
    logic                c_last;
    logic                c_pcld;
    logic [PC_WIDTH-1:0] c_addr;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] c_pc_d;
    logic                c_ovf;
    logic                c_end;
    logic                ack;
    logic                opr_full;

    // Stage completion: the OPR path uses the controls registered at request
    always_comb begin
        use_reg = (state_q == S_OPR);
        c_last  = use_reg ? last_q      : i_mc_last;
        c_pcld  = use_reg ? pcld_q      : i_pc_load;
        c_addr  = use_reg ? pcld_addr_q : i_pc_load_addr;
        pc_inc  = pc_q + PC_ONE;
        c_pc_d  = c_pcld ? c_addr : (use_reg ? pc_inc : pc_q);
        c_ovf   = !c_last && (stage_q == 2'd3);
        c_end   = c_last || c_ovf;
        ack     = req_q && i_mem_ack;
        opr_full = (cnt_q == 2'd2);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_VECTOR;
            instr_q     <= 8'h00;
            stage_q     <= 2'd0;
            mc_valid_q  <= 1'b0;
            opr0_q      <= 8'h00;
            opr1_q      <= 8'h00;
            cnt_q       <= 2'd0;
            seq_err_q   <= 1'b0;
            req_q       <= 1'b0;
            last_q      <= 1'b0;
            pcld_q      <= 1'b0;
            pcld_addr_q <= '0;
        end else begin
            seq_err_q <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (ack) begin
                        instr_q    <= i_mem_rdata;
                        pc_q       <= pc_inc;
                        stage_q    <= 2'd0;
                        cnt_q      <= 2'd0;
                        req_q      <= 1'b0;
                        mc_valid_q <= 1'b1;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (i_mc_stall) begin
                        state_q <= S_EXEC;
                    end else if (i_opr_req && !opr_full) begin
                        state_q     <= S_OPR;
                        mc_valid_q  <= 1'b0;
                        req_q       <= 1'b1;
                        last_q      <= i_mc_last;
                        pcld_q      <= i_pc_load;
                        pcld_addr_q <= i_pc_load_addr;
                    end else begin
                        // A third operand request completes without a fetch
                        seq_err_q <= c_ovf || i_opr_req;
                        pc_q      <= c_pc_d;
                        if (c_end) begin
                            state_q    <= S_FETCH;
                            mc_valid_q <= 1'b0;
                            req_q      <= 1'b1;
                        end else begin
                            stage_q <= stage_q + 2'd1;
                        end
                    end
                end
                S_OPR: begin
                    if (ack) begin
                        if (cnt_q == 2'd0) begin
                            opr0_q <= i_mem_rdata;
                        end else begin
                            opr1_q <= i_mem_rdata;
                        end
                        cnt_q     <= cnt_q + 2'd1;
                        pc_q      <= c_pc_d;
                        seq_err_q <= c_ovf;
                        if (c_end) begin
                            state_q    <= S_FETCH;
                            mc_valid_q <= 1'b0;
                            req_q      <= 1'b1;
                        end else begin
                            state_q    <= S_EXEC;
                            stage_q    <= stage_q + 2'd1;
                            mc_valid_q <= 1'b1;
                            req_q      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= S_FETCH;
                    mc_valid_q <= 1'b0;
                    req_q      <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_req      = req_q;
    assign o_mem_addr     = pc_q;
    assign o_instr_buffer = instr_q;
    assign o_ci_stage     = stage_q;
    assign o_mc_valid     = mc_valid_q;
    assign o_opr0         = opr0_q;
    assign o_opr1         = opr1_q;
    assign o_pc           = pc_q;
    assign o_seq_err      = seq_err_q;

endmodule

// File: tb/tb_mc8051_instr_sequencer.sv
// Directed bench for mc8051_instr_sequencer.
// Linear stimulus with hand-computed expectations.
module tb_mc8051_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  instr;
    logic [1:0]  stage;
    logic        mc_valid;
    logic [7:0]  opr0;
    logic [7:0]  opr1;
    logic [15:0] pc;
    logic        mc_last;
    logic        mc_stall;
    logic        opr_req;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic        seq_err;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mc8051_instr_sequencer #(
        .PC_WIDTH(16),
        .RESET_VECTOR(16'h0000)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .o_mem_req(mem_req),
        .o_mem_addr(mem_addr),
        .i_mem_ack(mem_ack),
        .i_mem_rdata(mem_rdata),
        .o_instr_buffer(instr),
        .o_ci_stage(stage),
        .o_mc_valid(mc_valid),
        .o_opr0(opr0),
        .o_opr1(opr1),
        .o_pc(pc),
        .i_mc_last(mc_last),
        .i_mc_stall(mc_stall),
        .i_opr_req(opr_req),
        .i_pc_load(pc_load),
        .i_pc_load_addr(pc_load_addr),
        .o_seq_err(seq_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        mem_ack = 0; mem_rdata = 8'h00; mc_last = 0; mc_stall = 0;
        opr_req = 0; pc_load = 0; pc_load_addr = 16'h0000;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clr();
        rst = 1;
        tick();
        chk("rst_req", mem_req, 0);
        chk("rst_instr", instr, 8'h00);
        chk("rst_stage", stage, 0);
        chk("rst_valid", mc_valid, 0);
        chk("rst_opr0", opr0, 0);
        chk("rst_opr1", opr1, 0);
        chk("rst_err", seq_err, 0);
        chk("rst_pc", pc, 16'h0000);

        rst = 0;
        tick();
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 16'h0000);
        mem_ack = 1; mem_rdata = 8'h00;
        tick();
        chk("t1_valid", mc_valid, 1);
        chk("t1_req_drop", mem_req, 0);
        chk("t1_pc", pc, 16'h0001);
        mem_ack = 0; mc_last = 1;
        tick();
        chk("t1_valid_1cyc", mc_valid, 0);
        chk("t1_req2", mem_req, 1);
        chk("t1_addr2", mem_addr, 16'h0001);

        // Jump to 0x0010 for the MOV A,#data case
        clr(); mem_ack = 1;
        tick();
        clr(); pc_load = 1; pc_load_addr = 16'h0010; mc_last = 1;
        tick();
        chk("mov_faddr", mem_addr, 16'h0010);
        clr(); mem_ack = 1; mem_rdata = 8'h74;
        tick();
        chk("mov_instr", instr, 8'h74);
        chk("mov_stage0", stage, 0);
        clr(); opr_req = 1;
        tick();
        chk("mov_opr_valid", mc_valid, 0);
        chk("mov_opr_req", mem_req, 1);
        chk("mov_opr_addr", mem_addr, 16'h0011);
        clr();
        tick();
        tick();
        chk("mov_hold_req", mem_req, 1);
        chk("mov_hold_addr", mem_addr, 16'h0011);
        mem_ack = 1; mem_rdata = 8'h5A;
        tick();
        chk("mov_opr0", opr0, 8'h5A);
        chk("mov_stage1", stage, 1);
        chk("mov_valid", mc_valid, 1);
        clr(); mc_last = 1;
        tick();
        chk("mov_next_req", mem_req, 1);
        chk("mov_next_addr", mem_addr, 16'h0012);

        // LJMP
        clr(); mem_ack = 1; mem_rdata = 8'h02;
        tick();
        clr();
        tick();
        tick();
        chk("ljmp_stage2", stage, 2);
        pc_load = 1; pc_load_addr = 16'h1234; mc_last = 1;
        tick();
        chk("ljmp_req", mem_req, 1);
        chk("ljmp_addr", mem_addr, 16'h1234);

        // Stall with mc_last held
        clr(); mem_ack = 1; mem_rdata = 8'h12;
        tick();
        clr();
        tick();
        chk("stall_stage1", stage, 1);
        mc_stall = 1; mc_last = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_stage", stage, 1);
            chk("stall_noreq", mem_req, 0);
        end
        mc_stall = 0;
        tick();
        chk("stall_rel_req", mem_req, 1);
        chk("stall_rel_addr", mem_addr, 16'h1235);

        // Stage overflow
        clr(); mem_ack = 1;
        tick();
        clr();
        tick();
        tick();
        tick();
        chk("ovf_stage3", stage, 3);
        chk("ovf_noerr", seq_err, 0);
        tick();
        chk("ovf_err", seq_err, 1);
        chk("ovf_req", mem_req, 1);
        chk("ovf_valid", mc_valid, 0);
        chk("ovf_addr", mem_addr, 16'h1236);
        tick();
        chk("ovf_err_pulse", seq_err, 0);

        // Two operands, then a third request
        mem_ack = 1;
        tick();
        clr(); opr_req = 1;
        tick();
        clr(); mem_ack = 1; mem_rdata = 8'hAA;
        tick();
        chk("op3_opr0", opr0, 8'hAA);
        clr(); opr_req = 1;
        tick();
        clr(); mem_ack = 1; mem_rdata = 8'hBB;
        tick();
        chk("op3_opr1", opr1, 8'hBB);
        chk("op3_stage2", stage, 2);
        clr(); opr_req = 1;
        tick();
        chk("op3_err", seq_err, 1);
        chk("op3_noreq", mem_req, 0);
        chk("op3_stage3", stage, 3);
        chk("op3_pc", pc, 16'h1239);
        clr(); mc_stall = 1; mem_ack = 1; mem_rdata = 8'hEE;
        tick();
        chk("stray_err", seq_err, 0);
        chk("stray_instr", instr, 8'h00);
        chk("stray_opr0", opr0, 8'hAA);
        clr(); mc_last = 1;
        tick();
        chk("op3_next_addr", mem_addr, 16'h1239);

        // PC wrap at 0xFFFF
        clr(); mem_ack = 1;
        tick();
        clr(); pc_load = 1; pc_load_addr = 16'hFFFF; mc_last = 1;
        tick();
        chk("wrap_addr", mem_addr, 16'hFFFF);
        clr(); mem_ack = 1; mem_rdata = 8'h55;
        tick();
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_instr", instr, 8'h55);
        clr(); mc_last = 1;
        tick();
        chk("wrap_req", mem_req, 1);

        // Reset mid-fetch with late ack
        clr(); rst = 1; mem_ack = 1; mem_rdata = 8'h99;
        tick();
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_instr", instr, 8'h00);
        rst = 0;
        tick();
        chk("late_ack_instr", instr, 8'h00);
        chk("late_ack_req", mem_req, 1);
        clr();
        tick();
        chk("late_ack_valid", mc_valid, 0);
        chk("late_ack_addr", mem_addr, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
